data_bus: RTL
=============

DATA_BUS -- requirements
Module: data_bus

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32'h1000, data RAM size in bytes (power of two).
REQ-002 SHALL have parameter CLOCK_HZ, default 48000000, clk48 frequency.
REQ-003 SHALL have parameter BAUD, default 115200, UART bit rate; DIV = CLOCK_HZ/BAUD (integer, 416 at defaults).
REQ-004 SHALL have port clk48  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port memory_address  input  32  byte address from core.
REQ-007 SHALL have port write_data  input  32  store data, little-endian.
REQ-008 SHALL have port memory_write_sections  input  3  bit0 = byte0, bit1 = byte1, bit2 = bytes 2 and 3; all zero = read cycle.
REQ-009 SHALL have port read_data  output  32  registered load data.
REQ-010 SHALL have port led_on  output  1  LED state, active-high.
REQ-011 SHALL have port uart_tx  output  1  UART serial out, idle high.

Function
REQ-012 SHALL decode the address map as follows: address[31]=0 is RAM, byte index = address mod RAM_SIZE; 0x8000_0000 is LED; 0x8000_0004 is UART; 0x8000_0008 is CYCLE; every other address is unmapped.
REQ-013 SHALL, on a RAM write, update only the bytes enabled by memory_write_sections: byte i at index (address+i) mod RAM_SIZE, taken from write_data[8i+7:8i]; the index wraps at RAM_SIZE.
REQ-014 SHALL, on a read cycle, load read_data at the clock edge with {RAM[a+3],RAM[a+2],RAM[a+1],RAM[a]} (indices mod RAM_SIZE), giving 1-cycle latency.
REQ-015 SHALL hold read_data unchanged on any write cycle.
REQ-016 SHALL, on any write to LED with nonzero sections, set led_on = (write_data != 0) at that edge; a LED read returns {31'b0, led_on}.
REQ-017 SHALL maintain CYCLE as a 32-bit free-running counter, +1 per clock, wrapping 0xFFFF_FFFF to 0; writes are ignored; a read returns the pre-increment value at the sampling edge.
REQ-018 SHALL, on a UART write with section bit0 set while busy=0, latch write_data[7:0] and start a frame; a write while busy=1 is dropped without error.
REQ-019 SHALL return {31'b0, busy} on a UART read, where busy=1 in every state except IDLE.
REQ-020 SHALL implement the UART FSM states IDLE, START, DATA, STOP: IDLE->START on accepted write; START drives 0 for DIV cycles ->DATA; DATA sends 8 bits LSB first, DIV cycles each, ->STOP after bit 7; STOP drives 1 for DIV cycles ->IDLE.
REQ-021 SHALL have uart_tx=1 in IDLE and STOP and never glitch between bit periods.
REQ-022 SHALL drive uart_tx low on the edge that accepts the write, so the start bit begins immediately.
REQ-023 SHALL ignore unmapped writes, and an unmapped read SHALL return 0.
REQ-024 SHALL have the bit-period counter count 0..DIV-1 and reset to 0 on each state or bit change.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force read_data=0, led_on=0, uart_tx=1, CYCLE=0, UART FSM=IDLE, bit counter=0, and busy=0.
REQ-026 SHALL abort a frame in progress on reset; after release, uart_tx stays 1 until a new write.
REQ-027 SHALL NOT reset RAM contents.
REQ-028 SHALL begin normal operation on the first rising edge after reset_n rises.

Verification
REQ-029 SHALL be verified by: write 0xDEADBEEF to 0x10 with sections 3'b111, then read 0x10 -> read_data 0xDEADBEEF one cycle after the read edge.
REQ-030 SHALL be verified by: 0x10 holding 0xDEADBEEF, write 0x000000AA with sections 3'b001, then read -> 0xDEADBEAA; a following write with 3'b100 and data 0x12340000 -> 0x1234BEAA.
REQ-031 SHALL be verified by: write 0x11223344 at address RAM_SIZE-2 -> bytes 0x44,0x33 at RAM_SIZE-2/-1 and 0x22,0x11 at indices 0/1; a read returns 0x11223344.
REQ-032 SHALL be verified by: write 5 to 0x8000_0000 -> led_on=1; write 0 -> led_on=0; a write with sections 0 leaves led_on unchanged.
REQ-033 SHALL be verified by: write 0x55 to 0x8000_0004 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each DIV cycles, busy=1 for 10*DIV cycles; a second write 0x0F mid-frame is dropped.
REQ-034 SHALL be verified by: assert reset_n=0 mid-DATA -> uart_tx=1 and busy=0 immediately; CYCLE read two cycles after release returns 1.

Source files
------------

// File: rtl/data_bus.sv
// Memory-mapped data bus: byte-enabled data RAM, LED register, free-running
// cycle counter and a transmit-only 8N1 UART, all behind one core port.
module data_bus #(
   parameter int unsigned RAM_SIZE = 32'h1000,
   parameter int unsigned CLOCK_HZ = 48000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic        clk48,
   input  logic        reset_n,
   input  logic [31:0] memory_address,
   input  logic [31:0] write_data,
   input  logic [2:0]  memory_write_sections,
   output logic [31:0] read_data,
   output logic        led_on,
   output logic        uart_tx
);

   localparam int unsigned DIV = CLOCK_HZ / BAUD;
   localparam int unsigned AW  = $clog2(RAM_SIZE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [31:0] LED_ADDR   = 32'h8000_0000;
   localparam logic [31:0] UART_ADDR  = 32'h8000_0004;
   localparam logic [31:0] CYCLE_ADDR = 32'h8000_0008;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   logic [7:0]    mem [RAM_SIZE];
   logic [AW-1:0] idx0, idx1, idx2, idx3;
   logic          is_ram, is_led, is_uart, is_cycle, is_write;
   logic [31:0]   rd_c;
   logic [31:0]   cycle_cnt;
   logic          busy;
   logic          accept;

   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          cnt_last;

   // Address decode; RAM byte indices wrap naturally in AW bits
   assign is_ram   = ~memory_address[31];
   assign is_led   = (memory_address == LED_ADDR);
   assign is_uart  = (memory_address == UART_ADDR);
   assign is_cycle = (memory_address == CYCLE_ADDR);
   assign is_write = |memory_write_sections;

   assign idx0 = memory_address[AW-1:0];
   assign idx1 = idx0 + AW'(1);
   assign idx2 = idx0 + AW'(2);
   assign idx3 = idx0 + AW'(3);

   assign busy     = (state != IDLE);
   assign accept   = is_uart & memory_write_sections[0] & ~busy;
   assign cnt_last = (cnt == CW'(DIV - 1));

   // Data RAM: byte-enabled writes, contents survive reset
   always_ff @(posedge clk48) begin
      if (is_ram) begin
         if (memory_write_sections[0]) mem[idx0] <= write_data[7:0];
         if (memory_write_sections[1]) mem[idx1] <= write_data[15:8];
         if (memory_write_sections[2]) begin
            mem[idx2] <= write_data[23:16];
            mem[idx3] <= write_data[31:24];
         end
      end
   end

   // Load data mux; unmapped addresses read as zero
   always_comb begin
      rd_c = '0;
      if (is_ram)
         rd_c = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
      else if (is_led)
         rd_c = {31'b0, led_on};
      else if (is_uart)
         rd_c = {31'b0, busy};
      else if (is_cycle)
         rd_c = cycle_cnt;
   end

   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         read_data <= '0;
         led_on    <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (!is_write)
            read_data <= rd_c;
         if (is_led && is_write)
            led_on <= (write_data != 32'd0);
      end
   end

   // UART transmitter; uart_tx is registered so it only moves on bit boundaries
   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  state   <= START;
                  shift   <= write_data[7:0];
                  uart_tx <= 1'b0;
               end
            end
            START: begin
               if (cnt_last) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  uart_tx <= shift[0];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt_last) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     uart_tx <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               uart_tx <= 1'b1;
               if (cnt_last) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule
